// File: rtl/ahblite_s_port.sv
// AHB-Lite slave port of the multi-master interconnect: round-robin address arbitration
// with lock override, per-master capture slots for stalled losers, and data-phase routing.
module ahblite_s_port #(
  parameter int unsigned AHB_AW  = 32,
  parameter int unsigned AHB_DW  = 32,
  parameter int unsigned MST_NUM = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m_hready_i    [MST_NUM],
  input  logic              m_hsel_i      [MST_NUM],
  input  logic [AHB_AW-1:0] m_haddr_i     [MST_NUM],
  input  logic              m_hwrite_i    [MST_NUM],
  input  logic [1:0]        m_htrans_i    [MST_NUM],
  input  logic [2:0]        m_hsize_i     [MST_NUM],
  input  logic [2:0]        m_hburst_i    [MST_NUM],
  input  logic [3:0]        m_hprot_i     [MST_NUM],
  input  logic              m_hmastlock_i [MST_NUM],
  input  logic [AHB_DW-1:0] m_hwdata_i    [MST_NUM],
  output logic              m_hreadyout_o [MST_NUM],
  output logic              m_hresp_o     [MST_NUM],
  output logic [AHB_DW-1:0] m_hrdata_o    [MST_NUM],
  output logic              hsel_o,
  output logic [AHB_AW-1:0] haddr_o,
  output logic              hwrite_o,
  output logic [1:0]        htrans_o,
  output logic [2:0]        hsize_o,
  output logic [2:0]        hburst_o,
  output logic [3:0]        hprot_o,
  output logic              hmastlock_o,
  output logic [AHB_DW-1:0] hwdata_o,
  output logic              hready_o,
  input  logic              hreadyout_i,
  input  logic              hresp_i,
  input  logic [AHB_DW-1:0] hrdata_i
);

  localparam int unsigned IW = (MST_NUM > 1) ? $clog2(MST_NUM) : 1;

  typedef struct packed {
    logic [AHB_AW-1:0] haddr;
    logic              hwrite;
    logic [1:0]        htrans;
    logic [2:0]        hsize;
    logic [2:0]        hburst;
    logic [3:0]        hprot;
    logic              hmastlock;
  } addr_ph_t;

  typedef enum logic {SLOT_IDLE, SLOT_PEND} slot_st_t;

  slot_st_t          slot_st_q [MST_NUM];
  slot_st_t          slot_st_d [MST_NUM];
  addr_ph_t          slot_q    [MST_NUM];
  addr_ph_t          slot_d    [MST_NUM];
  addr_ph_t          live_ph   [MST_NUM];
  logic [IW-1:0]     rr_q, rr_d;
  logic              dp_valid_q, dp_valid_d;
  logic [IW-1:0]     dp_owner_q, dp_owner_d;
  logic              lock_q, lock_d;
  logic [IW-1:0]     lock_owner_q, lock_owner_d;

  logic [MST_NUM-1:0] live, pend, elig;
  logic               win_found, issue;
  logic [IW-1:0]      win_idx, idx;
  addr_ph_t           win_ph;

  // Candidate set: live address phases plus captured slots, restricted to the lock owner.
  always_comb begin
    for (int i = 0; i < int'(MST_NUM); i++) begin
      live[i]    = m_hsel_i[i] & m_hready_i[i];
      pend[i]    = (slot_st_q[i] == SLOT_PEND);
      elig[i]    = (pend[i] | live[i]) & (~lock_q | (lock_owner_q == IW'(i)));
      live_ph[i] = '{haddr: m_haddr_i[i], hwrite: m_hwrite_i[i], htrans: m_htrans_i[i],
                     hsize: m_hsize_i[i], hburst: m_hburst_i[i], hprot: m_hprot_i[i],
                     hmastlock: m_hmastlock_i[i]};
    end
  end

  // Round-robin search starting one past the last winner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    idx       = '0;
    for (int unsigned k = 1; k <= MST_NUM; k++) begin
      idx = IW'((32'(rr_q) + k) % MST_NUM);
      if (!win_found && elig[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
    win_ph = pend[win_idx] ? slot_q[win_idx] : live_ph[win_idx];
    issue  = hreadyout_i & win_found;
  end

  // Next-state: issue bookkeeping, lock tracking and loser capture.
  always_comb begin
    slot_st_d    = slot_st_q;
    slot_d       = slot_q;
    rr_d         = rr_q;
    dp_valid_d   = dp_valid_q;
    dp_owner_d   = dp_owner_q;
    lock_d       = lock_q;
    lock_owner_d = lock_owner_q;
    if (hreadyout_i) begin
      if (win_found) begin
        rr_d               = win_idx;
        dp_valid_d         = 1'b1;
        dp_owner_d         = win_idx;
        slot_st_d[win_idx] = SLOT_IDLE;
        lock_d             = win_ph.hmastlock;
        lock_owner_d       = win_idx;
      end else begin
        dp_valid_d = 1'b0;
        lock_d     = lock_q & m_hmastlock_i[lock_owner_q];
      end
    end
    for (int i = 0; i < int'(MST_NUM); i++) begin
      if (live[i] && !(issue && (win_idx == IW'(i)))) begin
        slot_st_d[i] = SLOT_PEND;
        slot_d[i]    = live_ph[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(MST_NUM); i++) begin
        slot_st_q[i] <= SLOT_IDLE;
        slot_q[i]    <= '0;
      end
      rr_q         <= IW'(MST_NUM - 1);
      dp_valid_q   <= 1'b0;
      dp_owner_q   <= '0;
      lock_q       <= 1'b0;
      lock_owner_q <= '0;
    end else begin
      slot_st_q    <= slot_st_d;
      slot_q       <= slot_d;
      rr_q         <= rr_d;
      dp_valid_q   <= dp_valid_d;
      dp_owner_q   <= dp_owner_d;
      lock_q       <= lock_d;
      lock_owner_q <= lock_owner_d;
    end
  end

  // Slave-side address/data and per-master response routing.
  always_comb begin
    hsel_o      = 1'b0;
    haddr_o     = '0;
    hwrite_o    = 1'b0;
    htrans_o    = 2'b00;
    hsize_o     = '0;
    hburst_o    = '0;
    hprot_o     = '0;
    hmastlock_o = 1'b0;
    if (win_found) begin
      hsel_o      = 1'b1;
      haddr_o     = win_ph.haddr;
      hwrite_o    = win_ph.hwrite;
      htrans_o    = win_ph.htrans;
      hsize_o     = win_ph.hsize;
      hburst_o    = win_ph.hburst;
      hprot_o     = win_ph.hprot;
      hmastlock_o = win_ph.hmastlock;
    end
    hready_o = hreadyout_i;
    hwdata_o = dp_valid_q ? m_hwdata_i[dp_owner_q] : '0;
    for (int i = 0; i < int'(MST_NUM); i++) begin
      m_hreadyout_o[i] = pend[i] ? 1'b0 :
                         (dp_valid_q && (dp_owner_q == IW'(i))) ? hreadyout_i : 1'b1;
      m_hresp_o[i]     = dp_valid_q && (dp_owner_q == IW'(i)) && hresp_i;
      m_hrdata_o[i]    = hrdata_i;
    end
  end

  // A pending master must see HREADY low, so it can never present a new live request.
  for (genvar g = 0; g < int'(MST_NUM); g++) begin : g_slot_chk
    a_single_slot: assert property (@(posedge clk) disable iff (rst) !(live[g] && pend[g]))
      else $error("second capture into pending slot %0d", g);
  end

endmodule

// File: tb/tb_ahblite_s_port.sv
// Bench for ahblite_s_port: per-cycle vector table plus an address scoreboard,
// with hand-written single-write and asynchronous-reset sequences.
module tb_ahblite_s_port;

  localparam int unsigned NM = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk, rst;
  logic          m_hready_i    [NM];
  logic          m_hsel_i      [NM];
  logic [AW-1:0] m_haddr_i     [NM];
  logic          m_hwrite_i    [NM];
  logic [1:0]    m_htrans_i    [NM];
  logic [2:0]    m_hsize_i     [NM];
  logic [2:0]    m_hburst_i    [NM];
  logic [3:0]    m_hprot_i     [NM];
  logic          m_hmastlock_i [NM];
  logic [DW-1:0] m_hwdata_i    [NM];
  logic          m_hreadyout_o [NM];
  logic          m_hresp_o     [NM];
  logic [DW-1:0] m_hrdata_o    [NM];
  logic          hsel_o, hwrite_o, hmastlock_o, hready_o;
  logic [AW-1:0] haddr_o;
  logic [1:0]    htrans_o;
  logic [2:0]    hsize_o, hburst_o;
  logic [3:0]    hprot_o;
  logic [DW-1:0] hwdata_o;
  logic          hreadyout_i, hresp_i;
  logic [DW-1:0] hrdata_i;

  ahblite_s_port #(.AHB_AW(AW), .AHB_DW(DW), .MST_NUM(NM)) dut (
    .clk(clk), .rst(rst),
    .m_hready_i(m_hready_i), .m_hsel_i(m_hsel_i), .m_haddr_i(m_haddr_i),
    .m_hwrite_i(m_hwrite_i), .m_htrans_i(m_htrans_i), .m_hsize_i(m_hsize_i),
    .m_hburst_i(m_hburst_i), .m_hprot_i(m_hprot_i), .m_hmastlock_i(m_hmastlock_i),
    .m_hwdata_i(m_hwdata_i), .m_hreadyout_o(m_hreadyout_o), .m_hresp_o(m_hresp_o),
    .m_hrdata_o(m_hrdata_o), .hsel_o(hsel_o), .haddr_o(haddr_o), .hwrite_o(hwrite_o),
    .htrans_o(htrans_o), .hsize_o(hsize_o), .hburst_o(hburst_o), .hprot_o(hprot_o),
    .hmastlock_o(hmastlock_o), .hwdata_o(hwdata_o), .hready_o(hready_o),
    .hreadyout_i(hreadyout_i), .hresp_i(hresp_i), .hrdata_i(hrdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] sel, rdy, lock;
    logic       hro, hresp;
    int         win, dp;
    logic [3:0] mro, mresp;
  } vec_t;

  typedef struct {
    int          m;
    logic [31:0] a;
  } sb_t;

  vec_t tbl[$];
  sb_t  sbq[$];
  int   total = 0;
  int   bad   = 0;
  logic [3:0] mro_v, mresp_v;

  always_comb begin
    mro_v   = '0;
    mresp_v = '0;
    for (int i = 0; i < int'(NM); i++) begin
      mro_v[i]   = m_hreadyout_o[i];
      mresp_v[i] = m_hresp_o[i];
    end
  end

  function automatic vec_t mk(logic [3:0] sel, logic [3:0] rdy, logic [3:0] lock, logic hro,
                              logic hresp, int win, int dp, logic [3:0] mro, logic [3:0] mresp);
    vec_t t;
    t.sel = sel; t.rdy = rdy; t.lock = lock; t.hro = hro; t.hresp = hresp;
    t.win = win; t.dp = dp; t.mro = mro; t.mresp = mresp;
    return t;
  endfunction

  function automatic logic [31:0] addr_of(int i, int v);
    return 32'(32'h1000 * (i + 1) + 4 * v);
  endfunction

  function automatic logic [31:0] wd(int i);
    return 32'hA0A0_0000 + 32'(i);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive_vec(input int v, input vec_t t);
    for (int i = 0; i < int'(NM); i++) begin
      m_hsel_i[i]      = t.sel[i];
      m_hready_i[i]    = t.rdy[i];
      m_hmastlock_i[i] = t.lock[i];
      m_haddr_i[i]     = addr_of(i, v);
      if (t.sel[i] && t.rdy[i]) sbq.push_back('{i, addr_of(i, v)});
    end
    hreadyout_i = t.hro;
    hresp_i     = t.hresp;
    hrdata_i    = 32'h5A5A_0000 + 32'(v);
  endtask

  task automatic check_vec(input int v, input vec_t t);
    int idx;
    check($sformatf("v%0d hsel", v), 32'(hsel_o), 32'(t.win >= 0));
    check($sformatf("v%0d htrans", v), 32'(htrans_o), (t.win >= 0) ? 32'd2 : 32'd0);
    if (t.win >= 0) begin
      idx = -1;
      for (int k = 0; k < sbq.size(); k++)
        if (idx < 0 && sbq[k].m == t.win) idx = k;
      total++;
      if (idx < 0) begin
        bad++;
        $display("FAIL v%0d haddr: no queued address phase for master %0d", v, t.win);
      end else begin
        total--;
        check($sformatf("v%0d haddr", v), haddr_o, sbq[idx].a);
        if (t.hro) sbq.delete(idx);
      end
    end
    check($sformatf("v%0d hwdata", v), hwdata_o, (t.dp >= 0) ? wd(t.dp) : 32'd0);
    check($sformatf("v%0d hready", v), 32'(hready_o), 32'(t.hro));
    check($sformatf("v%0d m_hreadyout", v), 32'(mro_v), 32'(t.mro));
    check($sformatf("v%0d m_hresp", v), 32'(mresp_v), 32'(t.mresp));
    check($sformatf("v%0d m_hrdata", v), m_hrdata_o[v % int'(NM)], 32'h5A5A_0000 + 32'(v));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < int'(NM); i++) m_hsel_i[i] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sbq.delete();
  endtask

  initial begin
    vec_t h;
    rst = 1'b1;
    hreadyout_i = 1'b1; hresp_i = 1'b0; hrdata_i = '0;
    for (int i = 0; i < int'(NM); i++) begin
      m_hsel_i[i] = 1'b0; m_hready_i[i] = 1'b1; m_haddr_i[i] = '0;
      m_hwrite_i[i] = 1'b1; m_htrans_i[i] = 2'b10; m_hsize_i[i] = 3'd2;
      m_hburst_i[i] = 3'd0; m_hprot_i[i] = 4'h3; m_hmastlock_i[i] = 1'b0;
      m_hwdata_i[i] = wd(i);
    end

    // sel, rdy, lock, hro, hresp, win, dp, mro, mresp ({m3,m2,m1,m0})
    tbl.push_back(mk(4'b0011, 4'b1111, 4'b0000, 1, 0,  0, -1, 4'b1111, 4'b0000));
    tbl.push_back(mk(4'b0011, 4'b1101, 4'b0000, 1, 0,  1,  0, 4'b1101, 4'b0000));
    tbl.push_back(mk(4'b0011, 4'b1110, 4'b0000, 1, 0,  0,  1, 4'b1110, 4'b0000));
    tbl.push_back(mk(4'b0011, 4'b1101, 4'b0000, 1, 0,  1,  0, 4'b1101, 4'b0000));
    tbl.push_back(mk(4'b0011, 4'b1110, 4'b0000, 1, 0,  0,  1, 4'b1110, 4'b0000));
    tbl.push_back(mk(4'b0011, 4'b1101, 4'b0000, 1, 0,  1,  0, 4'b1101, 4'b0000));
    tbl.push_back(mk(4'b0001, 4'b1110, 4'b0000, 1, 0,  0,  1, 4'b1110, 4'b0000));
    tbl.push_back(mk(4'b0000, 4'b1111, 4'b0000, 1, 0, -1,  0, 4'b1111, 4'b0000));
    tbl.push_back(mk(4'b0000, 4'b1111, 4'b0000, 1, 0, -1, -1, 4'b1111, 4'b0000));
    // wait states with m2 arriving mid data phase
    tbl.push_back(mk(4'b0001, 4'b1111, 4'b0000, 1, 0,  0, -1, 4'b1111, 4'b0000));
    tbl.push_back(mk(4'b0100, 4'b1110, 4'b0000, 0, 0,  2,  0, 4'b1110, 4'b0000));
    tbl.push_back(mk(4'b0100, 4'b1010, 4'b0000, 0, 0,  2,  0, 4'b1010, 4'b0000));
    tbl.push_back(mk(4'b0000, 4'b1011, 4'b0000, 1, 0,  2,  0, 4'b1011, 4'b0000));
    tbl.push_back(mk(4'b0000, 4'b1111, 4'b0000, 1, 0, -1,  2, 4'b1111, 4'b0000));
    // two-cycle error on m1
    tbl.push_back(mk(4'b0010, 4'b1111, 4'b0000, 1, 0,  1, -1, 4'b1111, 4'b0000));
    tbl.push_back(mk(4'b0000, 4'b1101, 4'b0000, 0, 1, -1,  1, 4'b1101, 4'b0010));
    tbl.push_back(mk(4'b0000, 4'b1111, 4'b0000, 1, 1, -1,  1, 4'b1111, 4'b0010));
    tbl.push_back(mk(4'b0000, 4'b1111, 4'b0000, 1, 0, -1, -1, 4'b1111, 4'b0000));
    // m0 locked burst of three while m1 waits
    tbl.push_back(mk(4'b0011, 4'b1111, 4'b0001, 1, 0,  0, -1, 4'b1111, 4'b0000));
    tbl.push_back(mk(4'b0011, 4'b1101, 4'b0001, 1, 0,  0,  0, 4'b1101, 4'b0000));
    tbl.push_back(mk(4'b0011, 4'b1101, 4'b0001, 1, 0,  0,  0, 4'b1101, 4'b0000));
    tbl.push_back(mk(4'b0010, 4'b1101, 4'b0000, 1, 0, -1,  0, 4'b1101, 4'b0000));
    tbl.push_back(mk(4'b0010, 4'b1101, 4'b0000, 1, 0,  1, -1, 4'b1101, 4'b0000));
    tbl.push_back(mk(4'b0000, 4'b1111, 4'b0000, 1, 0, -1,  1, 4'b1111, 4'b0000));

    repeat (2) @(posedge clk);
    #1;
    check("reset hsel", 32'(hsel_o), 32'd0);
    check("reset htrans", 32'(htrans_o), 32'd0);
    check("reset m_hreadyout", 32'(mro_v), 32'hF);
    check("reset m_hresp", 32'(mresp_v), 32'h0);
    rst = 1'b0;

    // single zero-wait write from m0
    @(posedge clk); #1;
    m_hsel_i[0] = 1'b1; m_haddr_i[0] = 32'h1000;
    @(negedge clk);
    check("wr haddr", haddr_o, 32'h1000);
    check("wr hsel", 32'(hsel_o), 32'd1);
    check("wr m0 ready c0", 32'(m_hreadyout_o[0]), 32'd1);
    @(posedge clk); #1;
    m_hsel_i[0] = 1'b0; m_hwdata_i[0] = 32'hDEADBEEF;
    @(negedge clk);
    check("wr hwdata", hwdata_o, 32'hDEADBEEF);
    check("wr m0 ready c1", 32'(m_hreadyout_o[0]), 32'd1);
    @(posedge clk); #1;
    m_hwdata_i[0] = wd(0);
    do_reset();

    @(posedge clk); #1;
    for (int v = 0; v < tbl.size(); v++) begin
      drive_vec(v, tbl[v]);
      @(negedge clk);
      check_vec(v, tbl[v]);
      @(posedge clk); #1;
    end
    check("scoreboard drained", 32'(sbq.size()), 32'd0);

    // asynchronous reset while m1 is pending
    h = mk(4'b0011, 4'b1111, 4'b0000, 1, 0, 0, -1, 4'b1111, 4'b0000);
    drive_vec(100, h);
    @(negedge clk);
    check_vec(100, h);
    @(posedge clk); #1;
    h = mk(4'b0000, 4'b1101, 4'b0000, 1, 0, 1, 0, 4'b1101, 4'b0000);
    drive_vec(101, h);
    #1 check_vec(101, h);
    #1 rst = 1'b1;
    #1;
    check("async rst hsel", 32'(hsel_o), 32'd0);
    check("async rst m1 ready", 32'(m_hreadyout_o[1]), 32'd1);
    check("async rst m_hreadyout", 32'(mro_v), 32'hF);
    check("async rst hwdata", hwdata_o, 32'd0);
    sbq.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ahblite_s_port.md
# ahblite_s_port

AHB-Lite slave port of the multi-master interconnect. It sits between the internal master ports (one per bus master) and one physical AHB-Lite slave. It arbitrates address phases round-robin, with a lock override, and captures losing address phases so the losing masters stall cleanly. It routes the slave's data-phase response back to the owning master.

## Interface
- `AHB_AW`, default 32: address width.
- `AHB_DW`, default 32: data width.
- `MST_NUM`, default 4: number of masters (≥2); index width `IW = $clog2(MST_NUM)`.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `m_hready_i[MST_NUM]`  in  1  per-master HREADY, as seen by that master.
- `m_hsel_i[MST_NUM]`  in  1  master i addresses this slave; already qualified by `htrans[1]`.
- `m_haddr_i`, `m_hwrite_i`, `m_htrans_i`, `m_hsize_i`, `m_hburst_i`, `m_hprot_i`, `m_hmastlock_i` `[MST_NUM]`  in  AW/1/2/3/3/4/1  per-master address-phase signals.
- `m_hwdata_i[MST_NUM]`  in  DW  per-master write data.
- `m_hreadyout_o[MST_NUM]`  out  1  per-master ready.
- `m_hresp_o[MST_NUM]`  out  1  per-master response.
- `m_hrdata_o[MST_NUM]`  out  DW  per-master read data.
- `hsel_o`, `haddr_o`, `hwrite_o`, `htrans_o`, `hsize_o`, `hburst_o`, `hprot_o`, `hmastlock_o`  out  to the slave.
- `hwdata_o`  out  DW  to the slave.
- `hready_o`  out  1  to the slave.
- `hreadyout_i`, `hresp_i`  in  1  from the slave.
- `hrdata_i`  in  DW  from the slave.

## Operation
- Live request `live[i] = m_hsel_i[i] & m_hready_i[i]`. The master's address phase completes this cycle.
- Per-master slot states:
  - IDLE.
  - PEND: address bundle captured, awaiting issue.
  - A PEND master is not in data phase; its `m_hreadyout_o` is held at 0.
- Candidates: `cand[i] = pend[i] | live[i]`. Mutually exclusive per master, because a PEND master sees `m_hready_i = 0`.
- Arbitration runs every cycle.
  - Round-robin starting at `rr_ptr+1` (mod MST_NUM).
  - If `lock_q` is set, only `lock_owner` is eligible.
- Issue cycle: `hreadyout_i = 1` and a winner exists.
  - Winner's bundle, from the slot if PEND else live inputs, goes to the slave with `hsel_o = 1`.
  - `rr_ptr <= winner`.
  - `dp_valid <= 1`, `dp_owner <= winner`.
  - `pend[winner] <= 0`.
  - `lock_q <= winner's hmastlock`, `lock_owner <= winner`.
- Any live non-winner, or any live master when `hreadyout_i = 0`: capture its bundle into its slot and set `pend[i] <= 1`.
- No winner with `hreadyout_i = 1`:
  - Outputs `hsel_o = 0`, `htrans_o = IDLE`, other address outputs 0.
  - `dp_valid <= 0`.
  - `lock_q <= lock_q & m_hmastlock_i[lock_owner]`.
- Address outputs during `hreadyout_i = 0` reflect the current arbitration but are not issued. The slave samples them only when `hready_o = 1`.
- `hready_o = hreadyout_i`.
- `hwdata_o = dp_valid ? m_hwdata_i[dp_owner] : 0`.
- `m_hreadyout_o[i]`:
  - 0 if `pend[i]`;
  - else `hreadyout_i` if `dp_valid & dp_owner == i`;
  - else 1.
- `m_hresp_o[i] = (dp_valid & dp_owner == i) ? hresp_i : 0`. The two-cycle ERROR response passes through unchanged.
- `m_hrdata_o[i] = hrdata_i` (broadcast).

## Timing
- Reset values:
  - all slots IDLE;
  - `dp_valid = 0`, `dp_owner = 0`;
  - `rr_ptr = MST_NUM-1`, so master 0 has first priority;
  - `lock_q = 0`, `lock_owner = 0`.
- Reset output values:
  - `hsel_o = 0`, `htrans_o = 2'b00`;
  - `m_hreadyout_o` all 1;
  - `m_hresp_o` all 0.
- Uncontended request: zero added latency.
  - Address reaches the slave combinationally in the same cycle.
  - Data phase starts in the next cycle.
- Contended loser: PEND for at least 1 cycle. It is issued from its slot on the first issue cycle it wins.
- Only one slot per master. A second capture while PEND is impossible and is flagged by an assertion.
- Asynchronous reset mid-operation:
  - slots, `dp_valid` and lock are cleared immediately;
  - all `m_hreadyout_o` go to 1 without waiting for a clock.

## Test plan
- Single write: m0 `live`, addr 0x1000, NONSEQ; next cycle hwdata 0xDEADBEEF, slave zero-wait -> `haddr_o = 0x1000` in cycle 0, `hwdata_o = 0xDEADBEEF` in cycle 1, `m_hreadyout_o[0] = 1` throughout.
- Collision after reset: m0 and m1 live in cycle 0 (0x100, 0x200) -> m0 issued in cycle 0; m1 PEND with `m_hreadyout_o[1] = 0` in cycle 1; `haddr_o = 0x200` issued in cycle 1; `m_hreadyout_o[1] = 1` in cycle 2.
- Round-robin: m0 and m1 request every opportunity for 6 issues -> grant sequence 0,1,0,1,0,1.
- Wait states: `hreadyout_i = 0` for 2 cycles during m0's data phase; m2 goes live in the first wait cycle -> m2 PEND, `m_hreadyout_o[0] = 0` for 2 cycles, m2 issued in the cycle `hreadyout_i` returns to 1.
- Error and lock:
  - `hresp_i = 1` for 2 cycles on m1's transfer -> only `m_hresp_o[1] = 1`.
  - m0 locked burst of 3 transfers while m1 requests -> m1 is issued only after m0 drops `hmastlock`.
- Reset while m1 is PEND -> `m_hreadyout_o[1] = 1` and `hsel_o = 0` asynchronously, before the next clock edge.
